// File: rtl/adc_sar_sequencer.sv
// ---------------------------------------------------------------------------
// adc_sar_sequencer
// Control FSM for the SAR ADC. Times the sampling phase, an optional
// extra-sample cycle and the N-cycle conversion phase. It exports the FSM
// state in the encoding shared with the reconstruction stage, captures the
// final code into a result register, and hands it downstream through a
// valid/ready handshake with a sticky overrun flag.
//
// Ports
//   clk            conversion clock
//   rstb           asynchronous reset, active-low
//   en             block enable; low aborts any conversion back to IDLE
//   start          single-shot trigger (level or pulse)
//   continuous     restart sampling right after every DONE
//   extra_sample   insert one EXTRA_SAMPLE cycle after sampling
//   sample_cycles  sampling duration minus one, latched on SAMPLE entry
//   dout_in        final code from the reconstruction stage
//   current_state  FSM state, shared encoding
//   sample         sampling switch control (high in SAMPLE only)
//   busy           high in every state except IDLE
//   result         captured conversion code
//   result_valid   result available downstream
//   result_ready   downstream accepts result
//   overrun        sticky: an unread result was overwritten
//   overrun_clr    synchronous clear of overrun
// ---------------------------------------------------------------------------
module adc_sar_sequencer #(
    parameter int N          = 8,
    parameter int STATE_SIZE = 4,
    parameter int SAMPLE_W   = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  en,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  extra_sample,
    input  logic [SAMPLE_W-1:0]   sample_cycles,
    input  logic [N-1:0]          dout_in,
    output logic [STATE_SIZE-1:0] current_state,
    output logic                  sample,
    output logic                  busy,
    output logic [N-1:0]          result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE         = STATE_SIZE'(0),
        S_SAMPLE       = STATE_SIZE'(1),
        S_EXTRA_SAMPLE = STATE_SIZE'(2),
        S_CONV         = STATE_SIZE'(3),
        S_DONE         = STATE_SIZE'(4)
    } state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [CW-1:0]       conv_cnt_q, conv_cnt_d;
    logic [N-1:0]        result_q;
    logic                result_valid_q;
    logic                overrun_q;
    logic                capture;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            samp_cnt_q <= '0;
            conv_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            conv_cnt_q <= conv_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        conv_cnt_d = conv_cnt_q;
        capture    = 1'b0;

        // Disable wins over every phase, including DONE, so an abort never
        // captures. Illegal codes land here too and fall back to IDLE.
        if (state_q != S_IDLE && !en) begin
            state_d    = S_IDLE;
            samp_cnt_d = '0;
            conv_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && (start || continuous)) begin
                        state_d    = S_SAMPLE;
                        samp_cnt_d = sample_cycles;
                    end
                end
                S_SAMPLE: begin
                    if (samp_cnt_q == '0) begin
                        if (extra_sample) begin
                            state_d = S_EXTRA_SAMPLE;
                        end else begin
                            state_d    = S_CONV;
                            conv_cnt_d = CW'(N - 1);
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q - 1'b1;
                    end
                end
                S_EXTRA_SAMPLE: begin
                    state_d    = S_CONV;
                    conv_cnt_d = CW'(N - 1);
                end
                S_CONV: begin
                    if (conv_cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        conv_cnt_d = conv_cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    capture = 1'b1;
                    if (continuous) begin
                        state_d    = S_SAMPLE;
                        samp_cnt_d = sample_cycles;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    samp_cnt_d = '0;
                    conv_cnt_d = '0;
                end
            endcase
        end
    end

    // Result register and handshake. A capture always refreshes the code;
    // overrun is raised only when the old code was still unclaimed, and a
    // new overrun event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (capture) begin
                result_q       <= dout_in;
                result_valid_q <= 1'b1;
            end else if (result_valid_q && result_ready) begin
                result_valid_q <= 1'b0;
            end

            if (capture && result_valid_q && !result_ready) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign current_state = state_q;
    assign sample        = (state_q == S_SAMPLE);
    assign busy          = (state_q != S_IDLE);
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_sar_sequencer
// Directed scenarios followed by a randomized phase. A behavioural model
// tracks each conversion as an offset from its first SAMPLE cycle and derives
// the expected phase from the latched sample length, extra-sample choice and
// N; the result/valid/overrun model applies the handshake rules directly.
// ---------------------------------------------------------------------------
module tb_adc_sar_sequencer;

    localparam int N          = 8;
    localparam int STATE_SIZE = 4;
    localparam int SAMPLE_W   = 4;

    logic                  clk = 1'b0;
    logic                  rstb;
    logic                  en;
    logic                  start;
    logic                  continuous;
    logic                  extra_sample;
    logic [SAMPLE_W-1:0]   sample_cycles;
    logic [N-1:0]          dout_in;
    logic [STATE_SIZE-1:0] current_state;
    logic                  sample;
    logic                  busy;
    logic [N-1:0]          result;
    logic                  result_valid;
    logic                  result_ready;
    logic                  overrun;
    logic                  overrun_clr;

    adc_sar_sequencer #(.N(N), .STATE_SIZE(STATE_SIZE), .SAMPLE_W(SAMPLE_W)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .en            (en),
        .start         (start),
        .continuous    (continuous),
        .extra_sample  (extra_sample),
        .sample_cycles (sample_cycles),
        .dout_in       (dout_in),
        .current_state (current_state),
        .sample        (sample),
        .busy          (busy),
        .result        (result),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: conversion = offset m_k from first SAMPLE cycle.
    bit           m_busy;
    int           m_k;
    int           m_sc;
    int           m_ex;
    logic [N-1:0] m_result;
    bit           m_valid;
    bit           m_ovr;

    function automatic int exp_state();
        if (!m_busy)                    return 0;
        if (m_k <= m_sc)                return 1;
        if (m_ex == 1 && m_k == m_sc+1) return 2;
        if (m_k <= m_sc + m_ex + N)     return 3;
        return 4;
    endfunction

    function automatic bit capture_pending();
        return m_busy && en && (exp_state() == 4);
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_k      = 0;
        m_sc     = 0;
        m_ex     = 0;
        m_result = '0;
        m_valid  = 0;
        m_ovr    = 0;
    endtask

    task automatic model_step();
        bit cap;
        bit ovr_set;
        cap     = capture_pending();
        ovr_set = cap && m_valid && !result_ready;
        if (cap) begin
            m_result = dout_in;
            m_valid  = 1;
        end else if (m_valid && result_ready) begin
            m_valid = 0;
        end
        if (ovr_set)          m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;

        if (m_busy) begin
            if (!en) begin
                m_busy = 0;
            end else if (cap) begin
                if (continuous) begin
                    m_k  = 0;
                    m_sc = int'(sample_cycles);
                end else begin
                    m_busy = 0;
                end
            end else begin
                if (m_k == m_sc) m_ex = int'(extra_sample);
                m_k++;
            end
        end else if (en && (start || continuous)) begin
            m_busy = 1;
            m_k    = 0;
            m_sc   = int'(sample_cycles);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",   32'(current_state), 32'(exp_state()));
        chk("sample",  32'(sample),        32'(exp_state() == 1));
        chk("busy",    32'(busy),          32'(m_busy));
        chk("result",  32'(result),        32'(m_result));
        chk("valid",   32'(result_valid),  32'(m_valid));
        chk("overrun", 32'(overrun),       32'(m_ovr));
    endtask

    // Inputs are driven 1 time unit after the edge; checks happen there too.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_to_capture(input string tag);
        int guard;
        guard = 0;
        while (!capture_pending() && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_to_idle(input string tag);
        int guard;
        guard = 0;
        while (m_busy && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int sc1_state(input int j);
        if (j >= 1 && j <= 3)  return 1;
        if (j == 4)            return 2;
        if (j >= 5 && j <= 12) return 3;
        if (j == 13)           return 4;
        return 0;
    endfunction

    // Single-shot timing: sample_cycles=2, extra_sample=1, dout_in=0xA5.
    task automatic scenario1(input string tag);
        en            = 1;
        continuous    = 0;
        result_ready  = 0;
        sample_cycles = 4'd2;
        extra_sample  = 1;
        dout_in       = 8'hA5;
        start         = 1;
        for (int j = 1; j <= 14; j++) begin
            tick();
            start = 0;
            chk({tag, "_seq"}, 32'(current_state), 32'(sc1_state(j)));
        end
        chk({tag, "_result"}, 32'(result),       32'h0000_00A5);
        chk({tag, "_valid"},  32'(result_valid), 32'd1);
        chk({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    initial begin
        logic [N-1:0] saved_r;
        logic         saved_v;
        int           guard;

        rstb          = 0;
        en            = 0;
        start         = 0;
        continuous    = 0;
        extra_sample  = 0;
        sample_cycles = '0;
        dout_in       = '0;
        result_ready  = 0;
        overrun_clr   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstb = 1;
        tick();

        // Scenario 1
        scenario1("s1");

        // Scenario 2: no extra sample, sample_cycles=0
        result_ready = 1;
        tick();
        result_ready  = 0;
        sample_cycles = '0;
        extra_sample  = 0;
        start         = 1;
        tick();
        start = 0;
        for (int j = 2; j <= 11; j++) begin
            dout_in = 8'($urandom);
            tick();
        end
        chk("s2_valid_at_10", 32'(result_valid), 32'd1);

        // Scenario 3: continuous, ready=1, sample_cycles=1
        result_ready  = 1;
        continuous    = 1;
        sample_cycles = 4'd1;
        extra_sample  = 0;
        for (int j = 0; j < 45; j++) begin
            dout_in = 8'($urandom);
            tick();
        end
        chk("s3_no_overrun", 32'(overrun), 32'd0);

        // Scenario 4: overrun, clear, and set-wins-over-clear
        result_ready = 0;
        run_to_capture("s4a");
        dout_in = 8'h3C;
        tick();
        run_to_capture("s4b");
        dout_in = 8'hC3;
        tick();
        chk("s4_overrun_set", 32'(overrun), 32'd1);
        chk("s4_overwrite",   32'(result),  32'h0000_00C3);
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        chk("s4_overrun_clr", 32'(overrun), 32'd0);
        run_to_capture("s4c");
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        chk("s4_set_wins", 32'(overrun), 32'd1);

        // Scenario 5: abort in CONV cycle 3, then start while busy
        continuous = 0;
        run_to_idle("s5a");
        sample_cycles = 4'd1;
        extra_sample  = 0;
        start         = 1;
        tick();
        start = 0;
        guard = 0;
        while (!(exp_state() == 3 && m_k == m_sc + m_ex + 3) && guard < 40) begin
            tick();
            guard++;
        end
        saved_r = result;
        saved_v = result_valid;
        en = 0;
        tick();
        chk("s5_abort_idle",   32'(current_state), 32'd0);
        chk("s5_abort_result", 32'(result),        32'(saved_r));
        chk("s5_abort_valid",  32'(result_valid),  32'(saved_v));
        en    = 1;
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        start = 1;
        tick();
        start = 0;
        run_to_idle("s5b");
        chk("s5_idle_after", 32'(busy), 32'd0);

        // Randomized phase
        for (int j = 0; j < 400; j++) begin
            en            = ($urandom_range(0, 29) != 0);
            start         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) continuous = ~continuous;
            extra_sample  = 1'($urandom);
            sample_cycles = SAMPLE_W'($urandom);
            dout_in       = 8'($urandom);
            result_ready  = 1'($urandom);
            overrun_clr   = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Scenario 6: async reset mid-SAMPLE with result_valid=1
        en           = 1;
        continuous   = 0;
        start        = 0;
        overrun_clr  = 0;
        result_ready = 0;
        run_to_idle("s6a");
        sample_cycles = '0;
        extra_sample  = 0;
        start         = 1;
        tick();
        start = 0;
        run_to_idle("s6b");
        chk("s6_valid_before", 32'(result_valid), 32'd1);
        sample_cycles = 4'd5;
        start         = 1;
        tick();
        start = 0;
        tick();
        #3;
        rstb = 0;
        #1;
        chk("s6_rst_state",   32'(current_state), 32'd0);
        chk("s6_rst_result",  32'(result),        32'd0);
        chk("s6_rst_valid",   32'(result_valid),  32'd0);
        chk("s6_rst_overrun", 32'(overrun),       32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstb = 1;
        check_all();
        scenario1("s6_rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
Name: adc_sar_sequencer

Overview:
Control FSM for the SAR ADC. It generates the shared `current_state` encoding that drives the reconstruction stage, and times the sampling, optional extra-sample and N-bit conversion phases. It captures the final code produced by reconstruction into a result register and presents it downstream through a valid/ready handshake with overrun detection. Single-shot and continuous conversion modes are supported.

Parameters:
- N, 8, converter resolution in bits; the CONV phase lasts N cycles.
- STATE_SIZE, 4, width of `current_state`; must be ≥3.
- SAMPLE_W, 4, width of the `sample_cycles` configuration field.

Ports:
- clk  input  1  conversion clock.
- rstb  input  1  asynchronous reset, active-low.
- en  input  1  block enable; when low, forces an abort to IDLE.
- start  input  1  single-shot trigger, sampled on clk; level or pulse accepted.
- continuous  input  1  when 1, restart sampling immediately after each DONE.
- extra_sample  input  1  when 1, insert one S_EXTRA_SAMPLE cycle after sampling.
- sample_cycles  input  SAMPLE_W  sampling duration minus one.
- dout_in  input  N  registered code from the reconstruction stage.
- current_state  output  STATE_SIZE  FSM state, shared encoding.
- sample  output  1  sampling switch control; high in S_SAMPLE only.
- busy  output  1  high in every state except S_IDLE.
- result  output  N  captured conversion code.
- result_valid  output  1  result available.
- result_ready  input  1  downstream accepts result.
- overrun  output  1  sticky flag: an unread result was overwritten.
- overrun_clr  input  1  synchronous clear of `overrun`.

Behaviour:
- State encoding (shared header): S_IDLE=0, S_SAMPLE=1, S_EXTRA_SAMPLE=2, S_CONV=3, S_DONE=4. Other codes are illegal and return to S_IDLE on the next edge.
- Reset values: current_state=S_IDLE, result=0, result_valid=0, overrun=0, internal counters=0.

State transitions (evaluated on each posedge clk):
- S_IDLE:
  - If en & (start | continuous): go to S_SAMPLE and latch sample_cycles into the sample counter.
- S_SAMPLE:
  - Lasts sample_cycles+1 cycles; sample_cycles=0 gives 1 cycle, all-ones gives 2^SAMPLE_W cycles.
  - Value is latched at entry; changes mid-phase are ignored.
  - At the end: go to S_EXTRA_SAMPLE if extra_sample=1 (sampled on the last SAMPLE cycle), else to S_CONV.
- S_EXTRA_SAMPLE:
  - Exactly 1 cycle, then S_CONV.
- S_CONV:
  - Exactly N cycles, counted by a down-counter loaded with N-1 on entry.
  - Then S_DONE.
- S_DONE:
  - 1 cycle. The result register loads dout_in on the clock edge ending S_DONE.
  - Next state: S_SAMPLE if en & continuous, else S_IDLE.
  - start is not required to re-trigger in continuous mode.

Enable, start and counters:
- en=0 in any non-IDLE state: go to S_IDLE next edge. No capture, result_valid unchanged, counters cleared.
- start while busy: ignored, not queued.
- Counters are sized to avoid wrap: sample counter SAMPLE_W bits, conversion counter clog2(N) bits.

Output handshake:
- Capture with result_valid=0: result_valid←1.
- result_valid & result_ready with no capture: result_valid←0.
- Capture together with result_valid & result_ready: result←new value, result_valid stays 1, no overrun.
- Capture with result_valid & !result_ready: result overwritten, result_valid stays 1, overrun←1.
- overrun_clr: clears overrun. If it coincides with a new overrun event, set wins.
- result is stable while result_valid=1 and no capture occurs.

Latency and throughput:
- Latency from start edge to result_valid: (sample_cycles+1) + extra_sample + N + 1 cycles after the state leaves IDLE.
- Continuous throughput: one result every (sample_cycles+1) + extra_sample + N + 1 cycles.

Test Plan:
1. Single-shot timing. N=8, sample_cycles=2, extra_sample=1, start pulse sampled at edge 0.
   -> current_state: SAMPLE for cycles 1-3, EXTRA_SAMPLE cycle 4, CONV cycles 5-12, DONE cycle 13, IDLE cycle 14.
   -> sample high only in cycles 1-3.
   -> With dout_in=0xA5 in cycle 13: result=0xA5 and result_valid=1 in cycle 14; busy low in cycle 14.
2. No extra sample. extra_sample=0, sample_cycles=0.
   -> SAMPLE 1 cycle, CONV 8 cycles, DONE 1 cycle; result_valid asserted 10 cycles after leaving IDLE.
3. Continuous mode with result_ready=1, sample_cycles=1, extra_sample=0.
   -> Back-to-back conversions, DONE→SAMPLE with no IDLE cycle, one result every 11 cycles.
   -> result_valid pulses 1 cycle each; overrun stays 0.
4. Overrun. continuous=1, result_ready=0 for two conversions.
   -> Second capture overwrites result and sets overrun=1.
   -> Asserting overrun_clr clears overrun; overrun_clr on the same cycle as a third overrun leaves overrun=1.
5. Abort. Drop en during CONV cycle 3.
   -> S_IDLE next edge, no capture, result and result_valid unchanged.
   -> start while busy in another run is ignored; state sequence is unchanged.
6. Async reset mid-conversion. rstb low during S_SAMPLE with result_valid=1.
   -> Immediately current_state=S_IDLE, result=0, result_valid=0, overrun=0.
   -> After rstb release, a new start behaves exactly as scenario 1.
